// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the reset-release supervisor.
// System-level integration reuses the same defaults from here.
package rst_seq_pkg;

  typedef enum logic [1:0] {HOLD, QUAL, RELEASE, RUN} rst_seq_state_t;

  localparam int DEF_N_STAGES  = 3;
  localparam int DEF_LOCK_QUAL = 16;
  localparam int DEF_STAGE_GAP = 8;
  localparam int DEF_MIN_HOLD  = 4;
  localparam int DEF_LOSS_W    = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter is shared by all phases, so it is sized for the longest one.
  function automatic int cnt_width(input int lock_qual, input int stage_gap, input int min_hold);
    return $clog2(max3(lock_qual, stage_gap, min_hold) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctl_sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into the local clock.
// Synchronous reset drives every stage to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      if (srst) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/rst_seq_ctl.sv
// Reset-release supervisor: qualifies PLL lock, then releases staged domain
// resets in order; lock loss or a soft request re-asserts every stage at once.
module rst_seq_ctl
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES  = DEF_N_STAGES,
  parameter int LOCK_QUAL = DEF_LOCK_QUAL,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int MIN_HOLD  = DEF_MIN_HOLD,
  parameter int LOSS_W    = DEF_LOSS_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pll_locked_i,
  input  logic                sw_rst_req_i,
  output logic [N_STAGES-1:0] stage_rst_o,
  output logic                ready_o,
  output logic                lock_loss_o,
  output logic [LOSS_W-1:0]   loss_cnt_o
);

  localparam int CNT_W = cnt_width(LOCK_QUAL, STAGE_GAP, MIN_HOLD);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_QUAL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

  rst_seq_state_t      state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [N_STAGES-1:0] stage_rst_reg, stage_rst_next;
  logic                ready_reg, ready_next;
  logic                lock_loss_reg, lock_loss_next;
  logic [LOSS_W-1:0]   loss_cnt_reg, loss_cnt_next;

  logic                lock_s;
  logic [IDX_W-1:0]    idx_inc;
  logic [N_STAGES-1:0] next_bit_mask;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk  (clk_i),
    .srst (rst_i),
    .d    (pll_locked_i),
    .q    (lock_s)
  );

  // One-hot of the stage that the next gap expiry will release.
  assign idx_inc = idx_reg + IDX_W'(1);
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_mask
    assign next_bit_mask[gi] = (idx_inc == IDX_W'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= HOLD;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      stage_rst_reg <= '1;
      ready_reg     <= 1'b0;
      lock_loss_reg <= 1'b0;
      loss_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      stage_rst_reg <= stage_rst_next;
      ready_reg     <= ready_next;
      lock_loss_reg <= lock_loss_next;
      loss_cnt_reg  <= loss_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    stage_rst_next = stage_rst_reg;
    ready_next     = ready_reg;
    lock_loss_next = 1'b0;
    loss_cnt_next  = loss_cnt_reg;

    case (state_reg)
      HOLD: begin
        stage_rst_next = '1;
        ready_next     = 1'b0;
        if (cnt_reg == HOLD_LAST) begin
          state_next = QUAL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      QUAL: begin
        // A dropout here only restarts qualification; lock was never declared.
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt_reg == QUAL_LAST) begin
          state_next        = RELEASE;
          idx_next          = '0;
          cnt_next          = '0;
          stage_rst_next[0] = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (idx_reg == IDX_LAST) begin
          state_next = RUN;
          ready_next = 1'b1;
          cnt_next   = '0;
        end else if (cnt_reg == GAP_LAST) begin
          idx_next       = idx_inc;
          cnt_next       = '0;
          stage_rst_next = stage_rst_reg & ~next_bit_mask;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RUN: begin
        ready_next     = 1'b1;
        stage_rst_next = '0;
      end

      default: begin
        state_next     = HOLD;
        cnt_next       = '0;
        stage_rst_next = '1;
        ready_next     = 1'b0;
      end
    endcase

    // Abort path; lock loss takes precedence so a coincident soft request still counts.
    if ((state_reg == RELEASE || state_reg == RUN) && (!lock_s || sw_rst_req_i)) begin
      state_next     = HOLD;
      cnt_next       = '0;
      idx_next       = '0;
      stage_rst_next = '1;
      ready_next     = 1'b0;
      if (!lock_s) begin
        lock_loss_next = 1'b1;
        if (loss_cnt_reg != '1) begin
          loss_cnt_next = loss_cnt_reg + LOSS_W'(1);
        end
      end
    end
  end

  assign stage_rst_o = stage_rst_reg;
  assign ready_o     = ready_reg;
  assign lock_loss_o = lock_loss_reg;
  assign loss_cnt_o  = loss_cnt_reg;

endmodule

// File: tb/tb_rst_seq_ctl.sv
// Scoreboard bench: stimulus queues expected output changes with their edge
// number; a negedge monitor pops and compares whenever the outputs change.
module tb_rst_seq_ctl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, pll_locked_i, sw_rst_req_i;
  logic [2:0] stage_rst_o;
  logic       ready_o, lock_loss_o;
  logic [7:0] loss_cnt_o;

  logic       rst2, pll2, sw2;
  logic [1:0] stage2;
  logic       ready2, loss2;
  logic [1:0] loss_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rst_seq_ctl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pll_locked_i (pll_locked_i),
    .sw_rst_req_i (sw_rst_req_i),
    .stage_rst_o  (stage_rst_o),
    .ready_o      (ready_o),
    .lock_loss_o  (lock_loss_o),
    .loss_cnt_o   (loss_cnt_o)
  );

  rst_seq_ctl #(
    .N_STAGES  (2),
    .LOCK_QUAL (2),
    .STAGE_GAP (1),
    .MIN_HOLD  (1),
    .LOSS_W    (2)
  ) dut_w2 (
    .clk_i        (clk_i),
    .rst_i        (rst2),
    .pll_locked_i (pll2),
    .sw_rst_req_i (sw2),
    .stage_rst_o  (stage2),
    .ready_o      (ready2),
    .lock_loss_o  (loss2),
    .loss_cnt_o   (loss_cnt2)
  );

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [12:0] val;
  } ev_t;

  ev_t exp_q[$];

  task automatic push(input int c, input logic [2:0] s, input logic r, input logic l,
                      input logic [7:0] n);
    ev_t e;
    e.cyc = c;
    e.val = {s, r, l, n};
    exp_q.push_back(e);
  endtask

  // Full release sequence starting at the edge that drops stage 0.
  task automatic push_seq(input int t_rel, input logic [7:0] n);
    push(t_rel,      3'b110, 1'b0, 1'b0, n);
    push(t_rel + 8,  3'b100, 1'b0, 1'b0, n);
    push(t_rel + 16, 3'b000, 1'b0, 1'b0, n);
    push(t_rel + 17, 3'b000, 1'b1, 1'b0, n);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  logic [12:0] prev_out;
  bit          mon_en = 1'b0;

  always @(negedge clk_i) begin : mon
    logic [12:0] cur;
    ev_t         e;
    if (mon_en) begin
      cur = {stage_rst_o, ready_o, lock_loss_o, loss_cnt_o};
      if (ready_o) begin
        checks++;
        if (stage_rst_o != 3'b000) begin
          errors++;
          $display("FAIL ready_exclusive cyc=%0d stage_rst=%b while ready", cyc, stage_rst_o);
        end
      end
      if (cur !== prev_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b expected=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          checks += 2;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_time got cyc=%0d expected cyc=%0d (val=%b)", cyc, e.cyc, cur);
          end
          if (cur !== e.val) begin
            errors++;
            $display("FAIL event_value cyc=%0d got=%b expected=%b", cyc, cur, e.val);
          end
          if (cyc == e.cyc && cur === e.val)
            $display("ok   event cyc=%0d stage=%b ready=%b loss=%b cnt=%0d",
                     cyc, cur[12:10], cur[9], cur[8], cur[7:0]);
        end
        prev_out = cur;
      end
    end
  end

  initial begin
    rst_i = 1'b1; pll_locked_i = 1'b1; sw_rst_req_i = 1'b0;
    rst2 = 1'b1; pll2 = 1'b1; sw2 = 1'b0;

    wait_cyc(3);
    chk("reset_stage", 32'(stage_rst_o), 32'h7);
    chk("reset_ready", 32'(ready_o), 32'h0);
    chk("reset_loss_pulse", 32'(lock_loss_o), 32'h0);
    chk("reset_loss_cnt", 32'(loss_cnt_o), 32'h0);
    prev_out = {stage_rst_o, ready_o, lock_loss_o, loss_cnt_o};
    mon_en = 1'b1;

    // Power-up: 4 hold + 16 qual cycles after the last reset edge, then gaps of 8.
    rst_i = 1'b0;
    push_seq(23, 8'd0);

    // Lock loss in RUN.
    wait_cyc(45); pll_locked_i = 1'b0;
    push(48, 3'b111, 1'b0, 1'b1, 8'd1);
    push(49, 3'b111, 1'b0, 1'b0, 8'd1);
    wait_cyc(60); pll_locked_i = 1'b1;
    push_seq(78, 8'd1);

    // Second loss, then a 10-cycle lock blip inside QUAL must restart qualification.
    wait_cyc(100); pll_locked_i = 1'b0;
    push(103, 3'b111, 1'b0, 1'b1, 8'd2);
    push(104, 3'b111, 1'b0, 1'b0, 8'd2);
    wait_cyc(110); pll_locked_i = 1'b1;
    wait_cyc(120); pll_locked_i = 1'b0;
    wait_cyc(130); pll_locked_i = 1'b1;
    push_seq(148, 8'd2);

    // Soft reset in RUN, then again in RELEASE after stage 0 has dropped.
    wait_cyc(170); sw_rst_req_i = 1'b1;
    push(171, 3'b111, 1'b0, 1'b0, 8'd2);
    wait_cyc(171); sw_rst_req_i = 1'b0;
    push(191, 3'b110, 1'b0, 1'b0, 8'd2);
    wait_cyc(195); sw_rst_req_i = 1'b1;
    push(196, 3'b111, 1'b0, 1'b0, 8'd2);
    wait_cyc(196); sw_rst_req_i = 1'b0;
    push_seq(216, 8'd2);

    // Soft request on the same edge that sees lock loss: counted as a loss.
    wait_cyc(240); pll_locked_i = 1'b0;
    wait_cyc(242); sw_rst_req_i = 1'b1;
    push(243, 3'b111, 1'b0, 1'b1, 8'd3);
    push(244, 3'b111, 1'b0, 1'b0, 8'd3);
    wait_cyc(243); sw_rst_req_i = 1'b0;

    // rst_i mid-RELEASE clears everything including the loss count.
    wait_cyc(250); pll_locked_i = 1'b1;
    push(268, 3'b110, 1'b0, 1'b0, 8'd3);
    push(276, 3'b100, 1'b0, 1'b0, 8'd3);
    wait_cyc(280); rst_i = 1'b1;
    push(281, 3'b111, 1'b0, 1'b0, 8'd0);
    wait_cyc(281); rst_i = 1'b0;
    push_seq(301, 8'd0);

    wait_cyc(330);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    // Narrow loss counter: five losses saturate at 3.
    chk("w2_reset_stage", 32'(stage2), 32'h3);
    chk("w2_reset_cnt", 32'(loss_cnt2), 32'h0);
    rst2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      int n;
      n = 0;
      while (!ready2 && n < 40) begin
        @(posedge clk_i);
        #1;
        n++;
      end
      chk($sformatf("w2_ready_%0d", i), 32'(ready2), 32'h1);
      pll2 = 1'b0;
      repeat (6) @(posedge clk_i);
      #1;
      chk($sformatf("w2_loss_cnt_%0d", i), 32'(loss_cnt2), (i > 3) ? 32'h3 : 32'(i));
      chk($sformatf("w2_not_ready_%0d", i), 32'(ready2), 32'h0);
      pll2 = 1'b1;
    end
    rst2 = 1'b1;
    @(posedge clk_i);
    #1;
    chk("w2_rst_clears_cnt", 32'(loss_cnt2), 32'h0);
    chk("w2_rst_stage", 32'(stage2), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
